video_mem_server: RTL and testbench

VIDEO_MEM_SERVER -- requirements
Module: video_mem_server

---
 rtl/common.sv | 19 +
 rtl/video_mem_server.sv | 122 ++++++++++++
 tb/tb_video_mem_server.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/common.sv
// common: shared types and constants for the video memory server.
//   state_t              - access sequencer states
//   PALETTE_BASE_DEFAULT - SRAM byte address of the 64-entry ULA+ palette
package common;

    typedef enum logic [2:0] {
        IDLE,
        VRD0,
        VRD1,
        CRD0,
        CRD1,
        CWR0,
        CWR1,
        CWR2
    } state_t;

    localparam logic [18:0] PALETTE_BASE_DEFAULT = 19'h7FFC0;

endpackage

// File: rtl/video_mem_server.sv
// video_mem_server: arbitrates one asynchronous SRAM between video fetch and CPU.
// Ports:
//   clk28, rst_n                      - 28 MHz clock, async active-low reset
//   screen_page                       - 0: screen in page 5, 1: page 7
//   vid_req, vid_req_is_up,
//   vid_req_addr                      - video read request (screen or palette)
//   vid_ack, vid_data_valid, vid_data - video accept pulse, read-data pulse, byte
//   cpu_req, cpu_wr, cpu_addr,
//   cpu_wdata                         - CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata_valid,
//   cpu_rdata                         - CPU accept pulse, read-data pulse, byte
//   ram_a, ram_dout, ram_din          - SRAM address, write data, read data
//   ram_oe_n, ram_we_n, ram_dout_en   - SRAM enables and data bus drive enable
module video_mem_server
    import common::*;
#(
    parameter logic [18:0] PALETTE_BASE   = PALETTE_BASE_DEFAULT,
    parameter int          CPU_STARVE_MAX = 3
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        screen_page,
    input  logic        vid_req,
    input  logic        vid_req_is_up,
    input  logic [14:0] vid_req_addr,
    output logic        vid_ack,
    output logic        vid_data_valid,
    output logic [7:0]  vid_data,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rdata_valid,
    output logic [7:0]  cpu_rdata,
    output logic [18:0] ram_a,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic        ram_dout_en
);

    localparam int SW = $clog2(CPU_STARVE_MAX + 2);
    localparam logic [SW-1:0] SMAX = SW'(CPU_STARVE_MAX);

    state_t        state, next_state;
    logic [SW-1:0] starve;
    logic          decision, cpu_win, vid_win;
    logic          unused_addr_bit;

    assign unused_addr_bit = vid_req_addr[14];

    function automatic logic [18:0] vid_addr(input logic up, input logic page, input logic [13:0] a);
        return up ? {PALETTE_BASE[18:6], a[5:0]} : {2'b00, page ? 3'd7 : 3'd5, a};
    endfunction

    // Only the last cycle of each access (or IDLE) may start a new one,
    // which lets grants run back to back with no idle cycle.
    assign decision = state inside {IDLE, VRD1, CRD1, CWR2};
    assign cpu_win  = decision && cpu_req && (!vid_req || starve == SMAX);
    assign vid_win  = decision && vid_req && !cpu_win;

    always_comb begin
        next_state = IDLE;
        case (state)
            VRD0:    next_state = VRD1;
            CRD0:    next_state = CRD1;
            CWR0:    next_state = CWR1;
            CWR1:    next_state = CWR2;
            default: next_state = vid_win ? VRD0 : cpu_win ? (cpu_wr ? CWR0 : CRD0) : IDLE;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= next_state;
            starve <= (!cpu_req || cpu_win) ? '0 :
                      (vid_win && starve != SMAX) ? starve + 1'b1 : starve;
        end
    end

    // Every SRAM control is registered from next_state so strobes are glitch-free;
    // the async reset drops we_n/dout_en immediately even mid-write.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            vid_ack         <= 1'b0;
            cpu_ack         <= 1'b0;
            vid_data_valid  <= 1'b0;
            cpu_rdata_valid <= 1'b0;
            vid_data        <= '0;
            cpu_rdata       <= '0;
            ram_a           <= '0;
            ram_dout        <= '0;
            ram_oe_n        <= 1'b1;
            ram_we_n        <= 1'b1;
            ram_dout_en     <= 1'b0;
        end else begin
            vid_ack         <= vid_win;
            cpu_ack         <= cpu_win;
            ram_oe_n        <= !(next_state inside {VRD0, VRD1, CRD0, CRD1});
            ram_we_n        <= next_state != CWR1;
            ram_dout_en     <= next_state inside {CWR0, CWR1, CWR2};
            vid_data_valid  <= state == VRD1;
            cpu_rdata_valid <= state == CRD1;
            if (vid_win)
                ram_a <= vid_addr(vid_req_is_up, screen_page, vid_req_addr[13:0]);
            else if (cpu_win)
                ram_a <= cpu_addr;
            if (cpu_win && cpu_wr)
                ram_dout <= cpu_wdata;
            if (state == VRD1)
                vid_data <= ram_din;
            if (state == CRD1)
                cpu_rdata <= ram_din;
        end
    end

endmodule

// File: tb/tb_video_mem_server.sv
// tb_video_mem_server: scoreboard bench for video_mem_server.
//   Stimulus pushes expected grants/data into queues; a negedge monitor
//   pops and compares whenever the DUT pulses ack or valid.
module tb_video_mem_server;

    typedef struct packed {
        bit          is_cpu;
        bit          wr;
        logic [18:0] a;
        logic [7:0]  d;
    } exp_t;

    logic        clk28 = 1'b0;
    logic        rst_n = 1'b1;
    logic        screen_page = 1'b0;
    logic        vid_req = 1'b0;
    logic        vid_req_is_up = 1'b0;
    logic [14:0] vid_req_addr = '0;
    logic        vid_ack, vid_data_valid;
    logic [7:0]  vid_data;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack, cpu_rdata_valid;
    logic [7:0]  cpu_rdata;
    logic [18:0] ram_a;
    logic [7:0]  ram_dout, ram_din;
    logic        ram_oe_n, ram_we_n, ram_dout_en;

    exp_t       gq[$];
    logic [7:0] vq[$];
    logic [7:0] cq[$];

    int   tests = 0;
    int   fails = 0;
    int   timeouts = 0;
    bit   quiet = 0;
    bit   done = 0;

    video_mem_server dut (
        .clk28(clk28), .rst_n(rst_n), .screen_page(screen_page),
        .vid_req(vid_req), .vid_req_is_up(vid_req_is_up), .vid_req_addr(vid_req_addr),
        .vid_ack(vid_ack), .vid_data_valid(vid_data_valid), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata_valid(cpu_rdata_valid), .cpu_rdata(cpu_rdata),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_dout_en(ram_dout_en)
    );

    always #18 clk28 = ~clk28;

    function automatic logic [7:0] mem_f(input logic [18:0] a);
        return (a == 19'h1D800) ? 8'h38 : a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign ram_din = mem_f(ram_a);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_ctrl"}, 64'({vid_ack, vid_data_valid, cpu_ack, cpu_rdata_valid,
                                 ram_oe_n, ram_we_n, ram_dout_en}), 64'(7'b0000110));
        chk({tag, "_data"}, 64'({vid_data, cpu_rdata, ram_a, ram_dout}), 64'd0);
    endtask

    // Monitor / scoreboard
    bit          vack_d1, vack_d2, cack_d1, cack_d2, was_rst;
    int          wph;
    logic [18:0] wa;
    logic [7:0]  wd, lv, lc, dq;
    exp_t        e;

    always @(negedge clk28) begin
        if (!rst_n) begin
            rst_checks("reset");
            gq.delete();
            vq.delete();
            cq.delete();
            wph = 0;
            {vack_d1, vack_d2, cack_d1, cack_d2} = '0;
            lv = '0;
            lc = '0;
            was_rst = 1;
        end else begin
            if (was_rst) rst_checks("post_reset");
            was_rst = 0;
            chk("oe_dout_excl", 64'(!ram_oe_n && ram_dout_en), 64'd0);
            if (quiet)
                chk("idle", 64'({vid_ack, vid_data_valid, cpu_ack, cpu_rdata_valid,
                                 ram_oe_n, ram_we_n, ram_dout_en}), 64'(7'b0000110));
            if (wph == 1 || wph == 2) begin
                chk(wph == 1 ? "wr_we_low" : "wr_we_high", 64'(ram_we_n), 64'(wph == 2));
                chk("wr_hold", 64'({ram_a, ram_dout, ram_oe_n, ram_dout_en}), 64'({wa, wd, 2'b11}));
                wph = (wph == 1) ? 2 : 0;
            end
            if (vid_ack || cpu_ack) begin
                if (gq.size() == 0) begin
                    chk("unexp_ack", 64'({vid_ack, cpu_ack}), 64'd0);
                end else begin
                    e = gq.pop_front();
                    chk("grant_kind", 64'({vid_ack, cpu_ack}), 64'({!e.is_cpu, e.is_cpu}));
                    chk("ack_addr", 64'(ram_a), 64'(e.a));
                    if (e.is_cpu && e.wr) begin
                        chk("wr_setup", 64'({ram_dout, ram_oe_n, ram_we_n, ram_dout_en}), 64'({e.d, 3'b111}));
                        wph = 1;
                        wa = e.a;
                        wd = e.d;
                    end else begin
                        chk("rd_oe", 64'({ram_oe_n, ram_dout_en}), 64'd0);
                        if (e.is_cpu) cq.push_back(e.d);
                        else vq.push_back(e.d);
                    end
                end
            end
            if (vid_data_valid) begin
                if (vq.size() == 0) begin
                    chk("unexp_vid_valid", 64'd1, 64'd0);
                end else begin
                    dq = vq.pop_front();
                    chk("vid_data", 64'(vid_data), 64'(dq));
                    chk("vid_latency", 64'(vack_d2), 64'd1);
                end
                lv = vid_data;
            end else begin
                chk("vid_hold", 64'(vid_data), 64'(lv));
            end
            if (cpu_rdata_valid) begin
                if (cq.size() == 0) begin
                    chk("unexp_cpu_valid", 64'd1, 64'd0);
                end else begin
                    dq = cq.pop_front();
                    chk("cpu_rdata", 64'(cpu_rdata), 64'(dq));
                    chk("cpu_latency", 64'(cack_d2), 64'd1);
                end
                lc = cpu_rdata;
            end else begin
                chk("cpu_hold", 64'(cpu_rdata), 64'(lc));
            end
            vack_d2 = vack_d1;
            vack_d1 = vid_ack;
            cack_d2 = cack_d1;
            cack_d1 = cpu_ack;
            if (done) begin
                chk("drain", 64'(gq.size() + vq.size() + cq.size()), 64'd0);
                chk("timeouts", 64'(timeouts), 64'd0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    // Stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge clk28);
        #1;
    endtask

    task automatic wait_ack(input bit is_cpu);
        bit got = 0;
        for (int i = 0; i < 20; i++)
            if (!got) begin
                tick(1);
                got = is_cpu ? cpu_ack : vid_ack;
            end
        if (!got) timeouts++;
    endtask

    task automatic vid_rd(input logic page, input logic up, input logic [14:0] a, input logic [18:0] ea);
        exp_t x;
        x = '{is_cpu: 1'b0, wr: 1'b0, a: ea, d: mem_f(ea)};
        gq.push_back(x);
        screen_page = page;
        vid_req_is_up = up;
        vid_req_addr = a;
        vid_req = 1;
        wait_ack(0);
        vid_req = 0;
        screen_page = ~page;
        vid_req_addr = ~a;
        tick(4);
    endtask

    task automatic cpu_op(input logic wr, input logic [18:0] a, input logic [7:0] d);
        exp_t x;
        x = '{is_cpu: 1'b1, wr: wr, a: a, d: wr ? d : mem_f(a)};
        gq.push_back(x);
        cpu_wr = wr;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_req = 1;
        wait_ack(1);
        cpu_req = 0;
        cpu_addr = ~a;
        cpu_wdata = ~d;
    endtask

    initial begin
        int n;
        exp_t x;
        #2 rst_n = 0;
        repeat (3) @(posedge clk28);
        #1 rst_n = 1;
        quiet = 1;
        tick(10);
        quiet = 0;
        vid_rd(1'b1, 1'b0, 15'h5800, 19'h1D800);
        vid_rd(1'b0, 1'b1, 15'h002A, 19'h7FFEA);
        vid_rd(1'b0, 1'b0, 15'h0123, 19'h14123);
        cpu_op(1'b0, 19'h0ABCD, 8'h00);
        tick(4);
        cpu_op(1'b1, 19'h12345, 8'hA5);
        tick(5);
        for (int k = 0; k < 8; k++) begin
            x = (k % 4 == 3) ? '{is_cpu: 1'b1, wr: 1'b0, a: 19'h30000, d: mem_f(19'h30000)}
                             : '{is_cpu: 1'b0, wr: 1'b0, a: 19'h14010, d: mem_f(19'h14010)};
            gq.push_back(x);
        end
        screen_page = 0;
        vid_req_is_up = 0;
        vid_req_addr = 15'h0010;
        cpu_wr = 0;
        cpu_addr = 19'h30000;
        vid_req = 1;
        cpu_req = 1;
        n = 0;
        for (int i = 0; i < 60; i++)
            if (n < 2) begin
                tick(1);
                if (cpu_ack) n++;
            end
        if (n < 2) timeouts++;
        vid_req = 0;
        cpu_req = 0;
        tick(5);
        cpu_op(1'b1, 19'h12345, 8'h5C);
        @(posedge clk28);
        #3 rst_n = 0;
        tick(2);
        rst_n = 1;
        quiet = 1;
        tick(5);
        quiet = 0;
        done = 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
